// File: rtl/regfile_rw.sv
// 8 x 32-bit register file for the multi-cycle core: decodes operand registers in
// phase r and commits ALU writeback plus PUSH/POP stack-pointer adjustment in phase w.
module regfile_rw #(
    parameter int          SP_IDX  = 4,
    parameter logic [31:0] SP_INIT = 32'h0000_FFFC,
    parameter logic [31:0] SP_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  phase,
    input  logic [31:0] ir,
    input  logic [1:0]  we,
    input  logic [2:0]  wa,
    input  logic [31:0] wd,
    output logic [2:0]  ra1,
    output logic [2:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] sp
);

    localparam logic [2:0] SP_ADDR = 3'(SP_IDX);

    logic [31:0] regs      [0:7];
    logic [31:0] regs_next [0:7];

    logic       is_push;
    logic       is_pop;
    logic [2:0] dec_ra1;
    logic [2:0] dec_ra2;

    assign is_push = (ir[31:27] == 5'b01010);
    assign is_pop  = (ir[31:27] == 5'b01011);
    assign dec_ra1 = (is_push || is_pop) ? SP_ADDR   : ir[21:19];
    assign dec_ra2 = (is_push || is_pop) ? ir[26:24] : ir[18:16];

    // SP adjust first, then the data write, so a write to SP overrides the adjust.
    always_comb begin
        regs_next = regs;
        if (phase[4]) begin
            if (is_push) begin
                regs_next[SP_ADDR] = regs[SP_ADDR] - SP_STEP;
            end else if (is_pop) begin
                regs_next[SP_ADDR] = regs[SP_ADDR] + SP_STEP;
            end
            case (we)
                2'b01, 2'b11: regs_next[wa] = wd;
                2'b10:        regs_next[wa][15:0] = wd[15:0];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : 32'h0;
            end
        end else begin
            regs <= regs_next;
        end
    end

    // Operand latches read the array as it was before any same-edge writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1 <= 3'h0;
            ra2 <= 3'h0;
            rd1 <= 32'h0;
            rd2 <= 32'h0;
        end else if (phase[1]) begin
            ra1 <= dec_ra1;
            ra2 <= dec_ra2;
            rd1 <= regs[dec_ra1];
            rd2 <= regs[dec_ra2];
        end
    end

    assign sp = regs[SP_ADDR];

endmodule

// File: tb/tb_regfile_rw.sv
// Scoreboard bench for regfile_rw: a driver updates an array model and queues the
// expected outputs per edge; a monitor pops and compares after each edge or reset.
module tb_regfile_rw;

    localparam logic [31:0] SP_INIT = 32'h0000_FFFC;

    logic        clk;
    logic        rst;
    logic [4:0]  phase;
    logic [31:0] ir;
    logic [1:0]  we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sp;

    regfile_rw dut (
        .clk(clk), .rst(rst), .phase(phase), .ir(ir), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .sp(sp)
    );

    typedef struct {
        int          id;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mreg [8];
    logic [2:0]  m_ra1, m_ra2;
    logic [31:0] m_rd1, m_rd2;
    int          step_id;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int id,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, id, actual, expected);
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.id  = step_id;
        e.ra1 = m_ra1;
        e.ra2 = m_ra2;
        e.rd1 = m_rd1;
        e.rd2 = m_rd2;
        e.sp  = mreg[4];
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
        mreg[4] = SP_INIT;
        m_ra1 = 3'h0;
        m_ra2 = 3'h0;
        m_rd1 = 32'h0;
        m_rd2 = 32'h0;
    endtask

    // One clock edge of stimulus; the model applies the architectural effect of that edge.
    task automatic applyStimulus(input logic [4:0] ph, input logic [31:0] ir_v,
                                 input logic [1:0] we_v, input logic [2:0] wa_v,
                                 input logic [31:0] wd_v);
        bit stack_op, push_op, pop_op;
        @(posedge clk);
        #2;
        phase = ph;
        ir    = ir_v;
        we    = we_v;
        wa    = wa_v;
        wd    = wd_v;
        push_op  = (ir_v[31:27] == 5'b01010);
        pop_op   = (ir_v[31:27] == 5'b01011);
        stack_op = push_op || pop_op;
        if (ph[1]) begin
            m_ra1 = stack_op ? 3'd4 : ir_v[21:19];
            m_ra2 = stack_op ? ir_v[26:24] : ir_v[18:16];
            m_rd1 = mreg[m_ra1];
            m_rd2 = mreg[m_ra2];
        end
        if (ph[4]) begin
            if (push_op) mreg[4] = mreg[4] - 32'd4;
            if (pop_op)  mreg[4] = mreg[4] + 32'd4;
            if (we_v == 2'b01 || we_v == 2'b11) mreg[wa_v] = wd_v;
            else if (we_v == 2'b10) mreg[wa_v] = {mreg[wa_v][31:16], wd_v[15:0]};
        end
        pushExpected();
    endtask

    // Reset asserted between edges while a writeback is pending; checked before any edge.
    task automatic doReset();
        @(posedge clk);
        #2;
        phase = 5'b10000;
        we    = 2'b01;
        wa    = 3'd4;
        wd    = 32'hA5A5_A5A5;
        resetModel();
        pushExpected();
        rst = 1'b1;
        @(posedge clk);
        #2;
        phase = 5'b00000;
        we    = 2'b00;
        rst   = 1'b0;
    endtask

    function automatic logic [31:0] rdIr(input logic [2:0] a1, input logic [2:0] a2);
        return {10'h0, a1, a2, 16'h0};
    endfunction

    task automatic randomCycles(input int n);
        logic [31:0] r;
        logic [4:0]  ph;
        logic [4:0]  op;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
                0: ph = 5'b00001;
                1: ph = 5'b00010;
                2: ph = 5'b00100;
                3: ph = 5'b01000;
                4: ph = 5'b10000;
                default: ph = 5'($urandom_range(0, 31));
            endcase
            r = $urandom();
            case ($urandom_range(0, 3))
                0: op = 5'b01010;
                1: op = 5'b01011;
                default: op = r[31:27];
            endcase
            applyStimulus(ph, {op, r[26:0]}, 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), $urandom());
        end
    endtask

    // Monitor: after every clock edge or reset assertion, compare against the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("ra1", e.id, 32'(ra1), 32'(e.ra1));
                checkOutput("ra2", e.id, 32'(ra2), 32'(e.ra2));
                checkOutput("rd1", e.id, rd1, e.rd1);
                checkOutput("rd2", e.id, rd2, e.rd2);
                checkOutput("sp",  e.id, sp,  e.sp);
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        step_id = 0;
        rst   = 1'b0;
        phase = 5'b00000;
        ir    = 32'h0;
        we    = 2'b00;
        wa    = 3'h0;
        wd    = 32'h0;
        resetModel();

        $display("[TB] reset and readback");
        doReset();
        applyStimulus(5'b00010, rdIr(3'd0, 3'd1), 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b00010, rdIr(3'd2, 3'd3), 2'b00, 3'd0, 32'h0);

        $display("[TB] write then read, held through x/m/w");
        applyStimulus(5'b10000, 32'h0, 2'b01, 3'd3, 32'hDEAD_BEEF);
        applyStimulus(5'b00010, rdIr(3'd3, 3'd3), 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b00100, 32'h0, 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b01000, 32'h0, 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b10000, 32'h0, 2'b00, 3'd0, 32'h0);

        $display("[TB] half write");
        applyStimulus(5'b10000, 32'h0, 2'b01, 3'd2, 32'h1234_5678);
        applyStimulus(5'b10000, 32'h0, 2'b10, 3'd2, 32'hFFFF_AAAA);
        applyStimulus(5'b00010, rdIr(3'd2, 3'd0), 2'b00, 3'd0, 32'h0);

        $display("[TB] push and pop");
        applyStimulus(5'b00010, 32'h5300_0000, 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b10000, 32'h5300_0000, 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b10000, 32'h5C00_0000, 2'b01, 3'd4, 32'h0000_1000);
        applyStimulus(5'b10000, 32'h0, 2'b01, 3'd4, 32'hFFFF_FFFC);
        applyStimulus(5'b10000, 32'h5C00_0000, 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b00010, 32'h5C00_0000, 2'b00, 3'd0, 32'h0);

        $display("[TB] phase gating and r+w overlap");
        applyStimulus(5'b00001, 32'h0, 2'b01, 3'd5, 32'h1111_1111);
        applyStimulus(5'b00100, 32'h0, 2'b01, 3'd5, 32'h2222_2222);
        applyStimulus(5'b01000, 32'h0, 2'b11, 3'd5, 32'h3333_3333);
        applyStimulus(5'b00000, 32'h0, 2'b01, 3'd5, 32'h4444_4444);
        applyStimulus(5'b00010, rdIr(3'd5, 3'd1), 2'b00, 3'd0, 32'h0);
        applyStimulus(5'b10010, rdIr(3'd1, 3'd1), 2'b01, 3'd1, 32'h0000_0007);
        applyStimulus(5'b00010, rdIr(3'd1, 3'd1), 2'b00, 3'd0, 32'h0);

        $display("[TB] randomized traffic with mid-run reset");
        randomCycles(200);
        doReset();
        applyStimulus(5'b00010, 32'h5000_0000, 2'b00, 3'd0, 32'h0);
        randomCycles(200);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
            $fatal(1, "[TB] scoreboard did not drain");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
